// File: rtl/signed_divider_pkg.sv
// Shared constants for the sequential signed divider: FSM encodings,
// default operand width and the iteration-counter width.
package signed_divider_pkg;

    localparam int DEF_WIDTH = 8;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

endpackage

// File: rtl/signed_divider_div_step.sv
// One non-restoring division iteration: shift the partial remainder left
// bringing in the next dividend bit, then subtract or add the divisor
// depending on the sign of the current partial remainder.
module signed_divider_div_step
    import signed_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] m_ext_s;

    // Combinational shift / add-subtract / quotient-bit insertion.
    always_comb begin
        shifted_s = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
        m_ext_s   = {1'b0, m_in};
        if (a_in[WIDTH] == 1'b0) begin
            a_out = shifted_s - m_ext_s;
        end else begin
            a_out = shifted_s + m_ext_s;
        end
        q_out = {q_in[WIDTH-2:0], ~a_out[WIDTH]};
    end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider (C semantics: quotient truncates toward zero,
// remainder follows the dividend's sign). Operands are converted to
// magnitudes, divided with a non-restoring A/Q/M loop one bit per clock,
// then the signs are re-applied in a single fix-up cycle.
module signed_divider
    import signed_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state_r;
    logic [WIDTH:0]   a_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_r;
    logic [CW-1:0]    cnt_r;
    logic             sign_q_r;
    logic             sign_r_r;
    logic             dbz_r;
    logic             ovf_r;

    logic [WIDTH:0]   a_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] abs_dvd_s;
    logic [WIDTH-1:0] abs_dvs_s;
    logic             is_ovf_s;
    logic [WIDTH-1:0] r_mag_s;
    logic [WIDTH-1:0] q_fin_s;
    logic [WIDTH-1:0] r_fin_s;

    signed_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .a_in  (a_r),
        .q_in  (q_r),
        .m_in  (m_r),
        .a_out (a_next_s),
        .q_out (q_next_s)
    );

    // Operand magnitudes and the single overflowing operand pair (MIN / -1).
    always_comb begin
        abs_dvd_s = dividend;
        abs_dvs_s = divisor;
        if (dividend[WIDTH-1]) begin
            abs_dvd_s = ~dividend + WIDTH'(1);
        end else begin
            abs_dvd_s = dividend;
        end
        if (divisor[WIDTH-1]) begin
            abs_dvs_s = ~divisor + WIDTH'(1);
        end else begin
            abs_dvs_s = divisor;
        end
        is_ovf_s = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (divisor == {WIDTH{1'b1}});
    end

    // Remainder correction and sign re-application for the fix-up cycle;
    // only the low WIDTH bits of A matter once the correction is applied.
    always_comb begin
        r_mag_s = a_r[WIDTH-1:0];
        if (a_r[WIDTH]) begin
            r_mag_s = a_r[WIDTH-1:0] + m_r;
        end else begin
            r_mag_s = a_r[WIDTH-1:0];
        end
        if (sign_q_r) begin
            q_fin_s = ~q_r + WIDTH'(1);
        end else begin
            q_fin_s = q_r;
        end
        if (sign_r_r) begin
            r_fin_s = ~r_mag_s + WIDTH'(1);
        end else begin
            r_fin_s = r_mag_s;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= {(WIDTH+1){1'b0}};
            q_r         <= {WIDTH{1'b0}};
            m_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            sign_q_r    <= 1'b0;
            sign_r_r    <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        sign_q_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_r    <= dividend[WIDTH-1];
                        if (divisor == {WIDTH{1'b0}}) begin
                            // Keep the raw dividend in Q: it becomes the remainder.
                            dbz_r   <= 1'b1;
                            ovf_r   <= 1'b0;
                            q_r     <= dividend;
                            state_r <= FIX;
                        end else begin
                            dbz_r   <= 1'b0;
                            ovf_r   <= is_ovf_s;
                            a_r     <= {(WIDTH+1){1'b0}};
                            q_r     <= abs_dvd_s;
                            m_r     <= abs_dvs_s;
                            cnt_r   <= CW'(WIDTH);
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    a_r   <= a_next_s;
                    q_r   <= q_next_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    if (dbz_r) begin
                        quotient  <= {WIDTH{1'b1}};
                        remainder <= q_r;
                    end else begin
                        quotient  <= q_fin_s;
                        remainder <= r_fin_s;
                    end
                    div_by_zero <= dbz_r;
                    overflow    <= ovf_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider (WIDTH=8) against a plain
// integer-arithmetic reference of C-style signed division.
module tb_signed_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    signed_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: C semantics via SV integer division (truncates toward zero).
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            dz = 1'b1;
            q  = 8'hFF;
            r  = a;
        end else begin
            ov = (ai == -128) && (bi == -1);
            q  = 8'(ai / bi);
            r  = 8'(ai % bi);
        end
    endtask

    // Drive one operation and wait (bounded) for done; lat=0 means timeout.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cycles);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = $urandom_range(0, 255);
        divisor  = $urandom_range(0, 255);
        lat = 0;
        busy_cycles = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    // Run one operation and compare result, flags and latency to the model.
    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        logic         eov;
        int           lat;
        int           bc;
        int           elat;
        model(a, b, eq, er, edz, eov);
        elat = edz ? 2 : W + 2;
        do_op(a, b, lat, bc);
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency a=%h b=%h got=%0d exp=%0d", name, a, b, lat, elat);
        end
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
            errors++;
            $display("FAIL %s result a=%h b=%h got q=%h r=%h dz=%b ov=%b exp q=%h r=%h dz=%b ov=%b",
                     name, a, b, quotient, remainder, div_by_zero, overflow, eq, er, edz, eov);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dz=%b ov=%b exp all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        int bc;
        do_op(8'd100, 8'd7, lat, bc);
        checks++;
        if (bc !== 9 || lat !== 10) begin
            errors++;
            $display("FAIL basic_timing got busy=%0d done_at=%0d exp busy=9 done_at=10", bc, lat);
        end
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== {8'h0E, 8'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_100_7 got q=%h r=%h dz=%b ov=%b exp q=0e r=02 dz=0 ov=0",
                     quotient, remainder, div_by_zero, overflow);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || quotient !== 8'h0E || remainder !== 8'h02) begin
            errors++;
            $display("FAIL done_pulse_hold got done=%b q=%h r=%h exp done=0 q=0e r=02",
                     done, quotient, remainder);
        end
    endtask

    task automatic test_sign_matrix;
        check_op("neg_dvd", 8'(-100), 8'd7);
        check_op("neg_dvs", 8'd100, 8'(-7));
        check_op("neg_both", 8'(-100), 8'(-7));
        check_op("min_by_1", 8'h80, 8'd1);
    endtask

    task automatic test_special;
        check_op("div_zero", 8'd37, 8'd0);
        check_op("div_zero_neg", 8'h80, 8'd0);
        check_op("overflow", 8'h80, 8'hFF);
        check_op("min_by_min", 8'h80, 8'h80);
        check_op("small_by_big", 8'd3, 8'h81);
    endtask

    task automatic test_ignore_start;
        int lat;
        lat = 0;
        @(negedge clk);
        dividend = 8'd90;
        divisor  = 8'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        dividend = 8'(-55);
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 5; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 10 || quotient !== 8'd22 || remainder !== 8'd2) begin
            errors++;
            $display("FAIL ignore_start got done_at=%0d q=%h r=%h exp done_at=10 q=16 r=02",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int bc;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic edz;
        logic eov;
        do_op(8'd77, 8'(-9), lat, bc);
        checks++;
        if (lat !== 10 || quotient !== 8'(-8) || remainder !== 8'd5) begin
            errors++;
            $display("FAIL b2b_first got done_at=%0d q=%h r=%h exp done_at=10 q=f8 r=05",
                     lat, quotient, remainder);
        end
        // Still in the done cycle: request the next operation now.
        dividend = 8'(-121);
        divisor  = 8'd10;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got done=%b busy=%b exp done=0 busy=1", done, busy);
        end
        lat = 0;
        for (int c = 2; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        model(8'(-121), 8'd10, eq, er, edz, eov);
        checks++;
        if (lat !== 10 || quotient !== eq || remainder !== er) begin
            errors++;
            $display("FAIL b2b_second got done_at=%0d q=%h r=%h exp done_at=10 q=%h r=%h",
                     lat, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_reset_mid_calc;
        int lat;
        int bc;
        logic saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        dividend = 8'd99;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b q=%h r=%h dz=%b ov=%b exp all 0",
                     busy, done, quotient, remainder, div_by_zero, overflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got activity=%b exp 0", saw_done);
        end
        do_op(8'd50, 8'(-6), lat, bc);
        checks++;
        if (lat !== 10 || quotient !== 8'hF8 || remainder !== 8'h02) begin
            errors++;
            $display("FAIL after_reset got done_at=%0d q=%h r=%h exp done_at=10 q=f8 r=02",
                     lat, quotient, remainder);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0: b = 8'd0;
                1: b = 8'hFF;
                2: b = 8'h80;
                3: b = 8'd1;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 9) == 0) a = 8'h80;
            check_op("random", a, b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_matrix();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signed_divider.md
Name: signed_divider

Overview:
- Sequential signed integer divider for the computer-architecture datapath. It is the inverse operation to the Booth multiplier.
- Uses a non-restoring A/Q/M register scheme with one quotient bit per clock.
- Accepts a two's-complement dividend and divisor through a start/done handshake.
- Returns quotient and remainder with C semantics: truncation toward zero, remainder takes the dividend's sign.

Parameters:
- WIDTH, 8, operand/result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  signed two's-complement dividend, sampled with start
- divisor  input  WIDTH  signed two's-complement divisor, sampled with start
- busy  output  1  high from the edge that accepts start until the edge that asserts done
- done  output  1  one-cycle pulse; results are valid from this cycle onward
- quotient  output  WIDTH  signed quotient, held until the next accepted start
- remainder  output  WIDTH  signed remainder, held until the next accepted start
- div_by_zero  output  1  status for the last operation, valid with done
- overflow  output  1  status for the last operation, valid with done

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy, done, quotient, remainder, div_by_zero, overflow all 0.
  - Internal A/Q/M/count cleared.
  - Reset during CALC/FIX aborts the operation; no done pulse is issued.
- State IDLE, when start=1:
  - Clear the status flags.
  - If divisor==0: go to FIX with the zero flag latched.
  - Otherwise load Q=|dividend| and M=|divisor| as unsigned WIDTH bits (so -2^(WIDTH-1) maps to 2^(WIDTH-1)), A=0 (WIDTH+1 bits), count=WIDTH.
  - Latch sign_q = dividend[msb]^divisor[msb] and sign_r = dividend[msb].
  - Go to CALC.
  - busy rises on this edge.
- State CALC, one step per edge:
  - If A>=0: A = {A[WIDTH-1:0],Q[msb]} - M.
  - Otherwise: A = {A[WIDTH-1:0],Q[msb]} + M.
  - Q = {Q[WIDTH-2:0], ~A_new[msb]}.
  - count decrements; after WIDTH steps go to FIX.
- State FIX, single edge:
  - If A<0, add M to A (remainder correction).
  - Apply sign_q to Q and sign_r to A[WIDTH-1:0] by two's-complement negation; write quotient and remainder.
  - done=1, busy=0; go to IDLE.
- Latency:
  - Start accepted at edge E0; done is registered high after edge E0+WIDTH+1 and stays high for exactly one cycle.
  - Divide-by-zero: done after edge E0+1.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1, no iteration performed.
- Overflow: dividend = -2^(WIDTH-1) with divisor = -1 gives overflow=1, quotient = 2^(WIDTH-1) wrapped (8'h80 for WIDTH=8), remainder = 0.
- Operand and start rules:
  - start while busy=1 is ignored; operands are not re-sampled.
  - start in the same cycle as the done pulse is accepted; a back-to-back operation begins and done is low on the next cycle.
  - Operand inputs may change freely after acceptance.
- Arithmetic widths: A is WIDTH+1 bits; all additions are performed modulo 2^(WIDTH+1). Final negation is modulo 2^WIDTH.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, CALC=2'd1, FIX=2'd2;
  - the default WIDTH constant;
  - the counter width $clog2(WIDTH+1).
- One natural sub-module: div_step, a purely combinational single non-restoring iteration.
  - Inputs: A (WIDTH+1), Q (WIDTH), M (WIDTH).
  - Outputs: next A and next Q.
  - Instantiated once by the top-level FSM.

Test Plan:
- 100 / 7, start held for one cycle -> busy for 9 cycles, done on the 10th cycle after the start edge; quotient=8'h0E (14), remainder=8'h02, flags 0.
- Sign matrix:
  - -100 / 7 -> 8'hF2 (-14), 8'hFE (-2)
  - 100 / -7 -> 8'hF2, 8'h02
  - -100 / -7 -> 8'h0E, 8'hFE
  - -128 / 1 -> 8'h80, 8'h00, overflow=0
- 37 / 0 -> div_by_zero=1, quotient=8'hFF, remainder=8'h25, done one cycle after the start edge.
- -128 / -1 -> overflow=1, quotient=8'h80, remainder=8'h00, normal latency.
- Control sequencing:
  - start pulsed again mid-CALC with new operands -> ignored; first result returned unchanged.
  - start asserted on the done cycle -> second result correct.
- rst_n driven low for 2 cycles mid-CALC -> all outputs 0 asynchronously, no done pulse; a following 50 / -6 returns 8'hF8 (-8), 8'h02.
